// File: rtl/w5500_frame_pkg.sv
// -----------------------------------------------------------------------------
// w5500_frame_pkg
// Shared definitions for the W5500-style SPI target:
//   - frame FSM state encoding
//   - operating-mode (OM) codes and their fixed byte lengths
//   - control-byte field positions
//   - header echo bytes shifted out when W5500_HDR_ECHO_EN is defined
// No ports (package).
// -----------------------------------------------------------------------------
package w5500_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_CTRL = 3'd2,
        ST_DATA = 3'd3,
        ST_HOLD = 3'd4
    } frame_state_e;

    // Operating-mode field of the control byte.
    localparam logic [1:0] OM_VDM = 2'b00;  // variable length, until chip select rises
    localparam logic [1:0] OM_1B  = 2'b01;
    localparam logic [1:0] OM_2B  = 2'b10;
    localparam logic [1:0] OM_4B  = 2'b11;

    // Control byte layout: BSB[7:3], RWB[2], OM[1:0].
    localparam int CTRL_BSB_LSB = 3;
    localparam int CTRL_BSB_W   = 5;
    localparam int CTRL_RWB_BIT = 2;
    localparam int CTRL_OM_LSB  = 0;

    // Bytes a real W5500 shifts out while it receives the three header bytes.
    localparam logic [7:0] HDR_ECHO_ADDR_HI = 8'h01;
    localparam logic [7:0] HDR_ECHO_ADDR_LO = 8'h02;
    localparam logic [7:0] HDR_ECHO_CTRL    = 8'h03;

    // Data-phase length for the fixed-length modes; 0 means variable length.
    function automatic logic [2:0] om_fixed_len(input logic [1:0] om);
        case (om)
            OM_1B:   return 3'd1;
            OM_2B:   return 3'd2;
            OM_4B:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous SPI pin into the clk_i domain through a SYNC_FF deep
// flop chain and derives single-cycle rise/fall strobes from one extra
// history flop.
// Ports:
//   clk_i   in   system clock
//   rst_i   in   async active-high reset (chain resets low)
//   d_i     in   raw asynchronous input
//   q_o     out  synchronized level
//   rise_o  out  1-cycle strobe on a synchronized 0->1 transition
//   fall_o  out  1-cycle strobe on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int SYNC_FF = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_FF-1:0] sync_q;
    logic               prev_q;

    // NOTE: non-blocking assignments let every stage of the chain sample the
    // previous stage's old value, which is what makes it a shift register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_FF-2:0], d_i};
            prev_q <= sync_q[SYNC_FF-1];
        end
    end

    assign q_o    = sync_q[SYNC_FF-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/w5500_spi_target.sv
// -----------------------------------------------------------------------------
// w5500_spi_target
// SPI mode-0 target speaking the W5500 frame format
//   [addr 16b][ctrl 8b][data N bytes]
// and serving the data phase from a 32-bit BRAM port. Frames whose block
// select differs from BSB_SEL are unmapped: no BRAM access, reads return 0.
//
// Configuration macro: W5500_HDR_ECHO_EN
//   defined     -> MISO shifts 8'h01, 8'h02, 8'h03 during the header bytes
//   not defined -> MISO is 0 throughout the header
//
// Ports:
//   mclk          in   system clock (>= 8x spi_sclk)
//   reset         in   async active-high reset
//   spi_scsn      in   chip select, active low
//   spi_sclk      in   SPI clock, idle low
//   spi_mosi      in   serial data in, MSB first
//   spi_miso      out  serial data out
//   spi_miso_oe   out  MISO drive enable while selected and armed
//   mb_rst        out  BRAM reset (= reset)
//   mb_en         out  BRAM access strobe, one mclk
//   mb_we         out  byte-lane write enables
//   mb_addr       out  word-aligned byte address
//   mb_din        out  write byte replicated on all four lanes
//   mb_dout       in   BRAM read data, valid one mclk after mb_en
//   frame_done    out  1-cycle pulse when chip select ends a started frame
//   frame_err     out  qualifies frame_done: header incomplete or partial byte
//   frame_rw      out  RWB of the last frame (1 = write), held
//   frame_addr    out  start address of the last frame, held
// -----------------------------------------------------------------------------
module w5500_spi_target
    import w5500_frame_pkg::*;
#(
    parameter int         MB_AW   = 13,
    parameter logic [4:0] BSB_SEL = 5'h00,
    parameter int         SYNC_FF = 2
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             spi_scsn,
    input  logic             spi_sclk,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    output logic             mb_rst,
    output logic             mb_en,
    output logic [3:0]       mb_we,
    output logic [MB_AW-1:0] mb_addr,
    output logic [31:0]      mb_din,
    input  logic [31:0]      mb_dout,
    output logic             frame_done,
    output logic             frame_err,
    output logic             frame_rw,
    output logic [15:0]      frame_addr
);

`ifdef W5500_HDR_ECHO_EN
    localparam logic [7:0] ECHO_AH = HDR_ECHO_ADDR_HI;
    localparam logic [7:0] ECHO_AL = HDR_ECHO_ADDR_LO;
    localparam logic [7:0] ECHO_CT = HDR_ECHO_CTRL;
`else
    localparam logic [7:0] ECHO_AH = 8'h00;
    localparam logic [7:0] ECHO_AL = 8'h00;
    localparam logic [7:0] ECHO_CT = 8'h00;
`endif

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic scsn_s, scsn_rise, scsn_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.SYNC_FF(SYNC_FF)) u_sync_scsn (
        .clk_i (mclk),     .rst_i (reset),     .d_i    (spi_scsn),
        .q_o   (scsn_s),   .rise_o(scsn_rise), .fall_o (scsn_fall)
    );
    spi_sync_edge #(.SYNC_FF(SYNC_FF)) u_sync_sclk (
        .clk_i (mclk),     .rst_i (reset),     .d_i    (spi_sclk),
        .q_o   (sclk_s),   .rise_o(sclk_rise), .fall_o (sclk_fall)
    );
    spi_sync_edge #(.SYNC_FF(SYNC_FF)) u_sync_mosi (
        .clk_i (mclk),     .rst_i (reset),     .d_i    (spi_mosi),
        .q_o   (mosi_s),   .rise_o(mosi_rise), .fall_o (mosi_fall)
    );

    // Only the SCLK edges and the MOSI level are needed.
    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_s, mosi_rise, mosi_fall};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    frame_state_e     state_q;
    logic             armed_q;       // chip select seen high since reset
    logic [3:0]       bit_cnt_q;     // bit position within the current phase
    logic [14:0]      shift_q;       // MOSI history, MSB first
    logic [15:0]      addr_q;        // running byte address
    logic [15:0]      start_addr_q;  // address as received in the header
    logic             rwb_q;
    logic [1:0]       om_q;
    logic             mapped_q;
    logic [2:0]       byte_cnt_q;    // completed data bytes (fixed modes only)
    logic [7:0]       miso_sr_q;     // outgoing byte, MSB on the pin
    logic             skip_fall_q;   // next SCLK fall keeps a freshly loaded MSB
    logic             rd_wait_q;     // BRAM read issued this cycle
    logic             rd_load_q;     // BRAM read data valid this cycle
    logic [1:0]       rd_lane_q;
    logic             mb_en_q;
    logic [3:0]       mb_we_q;
    logic [MB_AW-1:0] mb_addr_q;
    logic [31:0]      mb_din_q;
    logic             frame_done_q;
    logic             frame_err_q;
    logic             frame_rw_q;
    logic [15:0]      frame_addr_q;

    // ------------------------------------------------------------------
    // Next-value helpers
    // ------------------------------------------------------------------
    logic [7:0]  rx_byte_d;
    logic [15:0] addr_inc_d;
    logic [2:0]  byte_cnt_inc_d;
    logic        ctrl_mapped_d;
    logic        fixed_done_d;
    logic [7:0]  rd_byte_d;

    assign rx_byte_d      = {shift_q[6:0], mosi_s};
    assign addr_inc_d     = addr_q + 16'd1;   // wraps FFFF -> 0000
    assign byte_cnt_inc_d = byte_cnt_q + 3'd1;
    assign ctrl_mapped_d  = (rx_byte_d[CTRL_BSB_LSB +: CTRL_BSB_W] == BSB_SEL);
    assign fixed_done_d   = (om_q != OM_VDM) && (byte_cnt_inc_d == om_fixed_len(om_q));

    // NOTE: every path assigns rd_byte_d, starting from a default, so this
    // block stays purely combinational with no inferred latch.
    always_comb begin
        rd_byte_d = 8'h00;
        case (rd_lane_q)
            2'd0: rd_byte_d = mb_dout[7:0];
            2'd1: rd_byte_d = mb_dout[15:8];
            2'd2: rd_byte_d = mb_dout[23:16];
            2'd3: rd_byte_d = mb_dout[31:24];
            default: rd_byte_d = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            addr_q       <= '0;
            start_addr_q <= '0;
            rwb_q        <= 1'b0;
            om_q         <= OM_VDM;
            mapped_q     <= 1'b0;
            byte_cnt_q   <= '0;
            miso_sr_q    <= '0;
            skip_fall_q  <= 1'b0;
            rd_wait_q    <= 1'b0;
            rd_load_q    <= 1'b0;
            rd_lane_q    <= '0;
            mb_en_q      <= 1'b0;
            mb_we_q      <= '0;
            mb_addr_q    <= '0;
            mb_din_q     <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_rw_q   <= 1'b0;
            frame_addr_q <= '0;
        end else begin
            // Strobes default low; the read pipeline advances every cycle.
            mb_en_q      <= 1'b0;
            mb_we_q      <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rd_wait_q    <= 1'b0;
            rd_load_q    <= rd_wait_q;

            if (scsn_s) begin
                armed_q <= 1'b1;
            end

            if (scsn_rise) begin
                if (state_q != ST_IDLE) begin
                    frame_done_q <= 1'b1;
                    frame_err_q  <= (state_q == ST_ADDR) || (state_q == ST_CTRL) ||
                                    ((state_q == ST_DATA) && (bit_cnt_q != 4'd0));
                    frame_rw_q   <= rwb_q;
                    frame_addr_q <= start_addr_q;
                end
                state_q     <= ST_IDLE;
                miso_sr_q   <= '0;
                skip_fall_q <= 1'b0;
                rd_wait_q   <= 1'b0;
                rd_load_q   <= 1'b0;
            end else if (scsn_fall && armed_q && (state_q == ST_IDLE)) begin
                // No SCLK fall precedes the first bit, so it goes straight out.
                state_q      <= ST_ADDR;
                bit_cnt_q    <= '0;
                rwb_q        <= 1'b0;
                start_addr_q <= '0;
                miso_sr_q    <= ECHO_AH;
                skip_fall_q  <= 1'b0;
            end else begin
                // MISO: a load lands between a byte's 8th rise and 8th fall,
                // so that fall must not shift the new MSB away.
                if (rd_load_q && (state_q == ST_DATA)) begin
                    miso_sr_q   <= rd_byte_d;
                    skip_fall_q <= 1'b1;
                end else if (sclk_fall && (state_q != ST_IDLE)) begin
                    if (skip_fall_q) begin
                        skip_fall_q <= 1'b0;
                    end else begin
                        miso_sr_q <= {miso_sr_q[6:0], 1'b0};
                    end
                end

                if (sclk_rise) begin
                    case (state_q)
                        ST_ADDR: begin
                            shift_q   <= {shift_q[13:0], mosi_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                miso_sr_q   <= ECHO_AL;
                                skip_fall_q <= 1'b1;
                            end
                            if (bit_cnt_q == 4'd15) begin
                                addr_q       <= {shift_q[14:0], mosi_s};
                                start_addr_q <= {shift_q[14:0], mosi_s};
                                bit_cnt_q    <= '0;
                                state_q      <= ST_CTRL;
                                miso_sr_q    <= ECHO_CT;
                                skip_fall_q  <= 1'b1;
                            end
                        end

                        ST_CTRL: begin
                            shift_q   <= {shift_q[13:0], mosi_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                rwb_q       <= rx_byte_d[CTRL_RWB_BIT];
                                om_q        <= rx_byte_d[CTRL_OM_LSB +: 2];
                                mapped_q    <= ctrl_mapped_d;
                                bit_cnt_q   <= '0;
                                byte_cnt_q  <= '0;
                                state_q     <= ST_DATA;
                                miso_sr_q   <= '0;
                                skip_fall_q <= 1'b1;
                                // First read byte is fetched while the
                                // master clocks the last control bit out.
                                if (!rx_byte_d[CTRL_RWB_BIT] && ctrl_mapped_d) begin
                                    mb_en_q   <= 1'b1;
                                    mb_addr_q <= {addr_q[MB_AW-1:2], 2'b00};
                                    rd_lane_q <= addr_q[1:0];
                                    rd_wait_q <= 1'b1;
                                end
                            end
                        end

                        ST_DATA: begin
                            shift_q   <= {shift_q[13:0], mosi_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q   <= '0;
                                addr_q      <= addr_inc_d;
                                miso_sr_q   <= '0;
                                skip_fall_q <= 1'b1;
                                if (om_q != OM_VDM) begin
                                    byte_cnt_q <= byte_cnt_inc_d;
                                end
                                if (rwb_q && mapped_q) begin
                                    mb_en_q   <= 1'b1;
                                    mb_we_q   <= 4'b0001 << addr_q[1:0];
                                    mb_addr_q <= {addr_q[MB_AW-1:2], 2'b00};
                                    mb_din_q  <= {4{rx_byte_d}};
                                end
                                if (fixed_done_d) begin
                                    state_q <= ST_HOLD;
                                end else if (!rwb_q && mapped_q) begin
                                    mb_en_q   <= 1'b1;
                                    mb_addr_q <= {addr_inc_d[MB_AW-1:2], 2'b00};
                                    rd_lane_q <= addr_inc_d[1:0];
                                    rd_wait_q <= 1'b1;
                                end
                            end
                        end

                        default: begin
                            // IDLE and HOLD ignore SCLK.
                        end
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign spi_miso    = miso_sr_q[7];
    assign spi_miso_oe = ~scsn_s & armed_q;
    assign mb_rst      = reset;
    assign mb_en       = mb_en_q;
    assign mb_we       = mb_we_q;
    assign mb_addr     = mb_addr_q;
    assign mb_din      = mb_din_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign frame_rw    = frame_rw_q;
    assign frame_addr  = frame_addr_q;

endmodule

// File: tb/tb_w5500_spi_target.sv
// -----------------------------------------------------------------------------
// tb_w5500_spi_target
// Drives W5500-format SPI frames into w5500_spi_target, emulates the BRAM
// behind its mb_* port, and compares MISO bytes, BRAM accesses and frame
// status against a byte-level model of the frame rules.
// -----------------------------------------------------------------------------
module tb_w5500_spi_target;

    localparam int         MB_AW   = 13;
    localparam logic [4:0] BSB_SEL = 5'h00;
    localparam int         HALF    = 5;          // mclk cycles per SCLK half period
    localparam int         WR_W    = MB_AW + 4 + 32;

`ifdef W5500_HDR_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic             mclk = 1'b0;
    logic             reset;
    logic             spi_scsn, spi_sclk, spi_mosi;
    logic             spi_miso, spi_miso_oe;
    logic             mb_rst, mb_en;
    logic [3:0]       mb_we;
    logic [MB_AW-1:0] mb_addr;
    logic [31:0]      mb_din;
    logic [31:0]      mb_dout = 32'h0;
    logic             frame_done, frame_err, frame_rw;
    logic [15:0]      frame_addr;

    always #5 mclk = ~mclk;

    w5500_spi_target #(.MB_AW(MB_AW), .BSB_SEL(BSB_SEL), .SYNC_FF(2)) dut (
        .mclk        (mclk),
        .reset       (reset),
        .spi_scsn    (spi_scsn),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .mb_rst      (mb_rst),
        .mb_en       (mb_en),
        .mb_we       (mb_we),
        .mb_addr     (mb_addr),
        .mb_din      (mb_din),
        .mb_dout     (mb_dout),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .frame_rw    (frame_rw),
        .frame_addr  (frame_addr)
    );

    // ------------------------------------------------------------------
    // BRAM attached to the DUT, and the reference byte memory
    // ------------------------------------------------------------------
    logic [31:0] bram    [0:2047];
    logic [7:0]  mem_ref [0:8191];

    always @(posedge mclk) begin
        if (mb_en) begin
            for (int l = 0; l < 4; l++) begin
                if (mb_we[l]) bram[mb_addr[MB_AW-1:2]][8*l +: 8] <= mb_din[8*l +: 8];
            end
            mb_dout <= bram[mb_addr[MB_AW-1:2]];
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    int              en_cnt, done_cnt;
    logic            done_err, done_rw;
    logic [15:0]     done_addr;
    logic [WR_W-1:0] wr_q [$];

    always @(negedge mclk) begin
        if (mb_en) begin
            en_cnt++;
            if (mb_we != 4'h0) wr_q.push_back({mb_addr, mb_we, mb_din});
        end
        if (frame_done) begin
            done_cnt++;
            done_err  = frame_err;
            done_rw   = frame_rw;
            done_addr = frame_addr;
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // SPI master
    // ------------------------------------------------------------------
    logic [7:0] tx_s [0:15];
    logic [7:0] rx_s [0:15];

    task automatic spi_bits(input int nbits);
        for (int i = 0; i < 16; i++) rx_s[i] = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx_s[i/8][7 - (i%8)];
            repeat (HALF) @(negedge mclk);
            spi_sclk = 1'b1;
            rx_s[i/8][7 - (i%8)] = spi_miso;
            repeat (HALF) @(negedge mclk);
            spi_sclk = 1'b0;
        end
    endtask

    function automatic int fixed_len(input logic [1:0] om);
        case (om)
            2'd1:    return 1;
            2'd2:    return 2;
            2'd3:    return 4;
            default: return 0;
        endcase
    endfunction

    // Model of one frame: what the DUT must have done given the bits sent.
    task automatic check_frame(input logic [15:0] addr, input logic [7:0] ctrl, input int total);
        bit         hdr    = (total >= 24);
        int         nfull  = hdr ? (total - 24) / 8 : 0;
        int         tail   = hdr ? (total - 24) % 8 : 0;
        bit         fixed  = (ctrl[1:0] != 2'd0);
        int         len    = fixed_len(ctrl[1:0]);
        bit         mapped = (ctrl[7:3] == BSB_SEL);
        bit         wr     = ctrl[2];
        int         eff    = (fixed && nfull > len) ? len : nfull;
        bit         hold   = fixed && (nfull >= len);
        int         exp_en;
        logic [15:0] a;
        logic [7:0]  eb;

        if (!hdr || !mapped)  exp_en = 0;
        else if (wr)          exp_en = eff;
        else if (fixed)       exp_en = (nfull + 1 < len) ? nfull + 1 : len;
        else                  exp_en = nfull + 1;

        check("done_cnt", done_cnt, 1);
        check("done_err", done_err, (!hdr || (tail != 0 && !hold)) ? 1 : 0);
        if (hdr) begin
            check("done_rw", done_rw, wr);
            check("done_addr", done_addr, addr);
        end
        check("mb_en_cnt", en_cnt, exp_en);

        for (int b = 0; b < 3; b++) begin
            if (total >= 8*(b+1)) check("miso_hdr", rx_s[b], ECHO ? 8'(b+1) : 8'h00);
        end
        for (int k = 0; k < nfull; k++) begin
            a  = addr + 16'(k);
            eb = (!wr && mapped && (!fixed || k < len)) ? mem_ref[a[12:0]] : 8'h00;
            check("miso_data", rx_s[3+k], eb);
        end

        if (hdr && wr && mapped) begin
            check("wr_cnt", wr_q.size(), eff);
            for (int k = 0; k < eff; k++) begin
                a = addr + 16'(k);
                mem_ref[a[12:0]] = tx_s[3+k];
                if (wr_q.size() > 0) begin
                    check("wr_evt", wr_q.pop_front(),
                          {a[12:2], 2'b00, 4'b0001 << a[1:0], {4{tx_s[3+k]}}});
                end
            end
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && done_cnt == 0; i++) @(negedge mclk);
        repeat (4) @(negedge mclk);
    endtask

    task automatic do_frame(input logic [15:0] addr, input logic [7:0] ctrl, input int total);
        tx_s[0] = addr[15:8];
        tx_s[1] = addr[7:0];
        tx_s[2] = ctrl;
        en_cnt   = 0;
        done_cnt = 0;
        wr_q.delete();
        @(negedge mclk);
        spi_scsn = 1'b0;
        repeat (HALF) @(negedge mclk);
        check("oe_sel", spi_miso_oe, 1);
        spi_bits(total);
        repeat (HALF) @(negedge mclk);
        spi_scsn = 1'b1;
        wait_done();
        check_frame(addr, ctrl, total);
        check("oe_idle", spi_miso_oe, 0);
        repeat (2*HALF) @(negedge mclk);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int         nbad;
        logic [15:0] ra;
        logic [7:0]  rc;
        int         nb, tot;

        reset    = 1'b1;
        spi_scsn = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        for (int w = 0; w < 2048; w++) begin
            bram[w] = $urandom;
            for (int l = 0; l < 4; l++) mem_ref[4*w + l] = bram[w][8*l +: 8];
        end
        repeat (3) @(negedge mclk);
        check("rst_miso", spi_miso, 0);
        check("rst_oe", spi_miso_oe, 0);
        check("rst_mb_rst", mb_rst, 1);
        check("rst_mb_en", mb_en, 0);
        check("rst_mb_we", mb_we, 0);
        check("rst_done", {frame_done, frame_err, frame_rw}, 0);
        check("rst_faddr", frame_addr, 0);
        reset = 1'b0;
        repeat (10) @(negedge mclk);
        check("mb_rst_rel", mb_rst, 0);

        // 1: variable-length write of four bytes
        tx_s[3] = 8'hAA; tx_s[4] = 8'hBB; tx_s[5] = 8'hCC; tx_s[6] = 8'hDD;
        do_frame(16'h0010, {BSB_SEL, 1'b1, 2'b00}, 24 + 32);
        check("t1_word", bram[4], 32'hDDCCBBAA);

        // 2: two-byte read from an unaligned address
        bram[8] = 32'h44332211;
        mem_ref[32] = 8'h11; mem_ref[33] = 8'h22; mem_ref[34] = 8'h33; mem_ref[35] = 8'h44;
        do_frame(16'h0021, {BSB_SEL, 1'b0, 2'b10}, 24 + 16);
        check("t2_b0", rx_s[3], 8'h22);
        check("t2_b1", rx_s[4], 8'h33);

        // 3: one-byte write followed by two ignored bytes
        tx_s[3] = 8'h5A; tx_s[4] = 8'h11; tx_s[5] = 8'h22;
        do_frame(16'h0102, {BSB_SEL, 1'b1, 2'b01}, 24 + 24);

        // 4: abort after 12 address bits, then a normal frame
        do_frame(16'h1234, {BSB_SEL, 1'b1, 2'b00}, 12);
        tx_s[3] = 8'h77; tx_s[4] = 8'h88;
        do_frame(16'h0200, {BSB_SEL, 1'b1, 2'b00}, 24 + 16);

        // 5: address wrap, then an unmapped read
        tx_s[3] = 8'hE1; tx_s[4] = 8'hE2;
        do_frame(16'hFFFF, {BSB_SEL, 1'b1, 2'b00}, 24 + 16);
        check("t5_hi", bram[2047][31:24], 8'hE1);
        check("t5_lo", bram[0][7:0], 8'hE2);
        do_frame(16'h0000, {BSB_SEL + 5'd1, 1'b0, 2'b00}, 24 + 24);

        // 6: reset while selected; frame ignored until chip select cycles
        for (int i = 0; i < 4; i++) tx_s[i] = 8'($urandom);
        @(negedge mclk);
        spi_scsn = 1'b0;
        repeat (HALF) @(negedge mclk);
        spi_bits(10);
        reset = 1'b1;
        @(negedge mclk);
        check("t6_rst_miso", spi_miso, 0);
        check("t6_rst_oe", spi_miso_oe, 0);
        check("t6_rst_en", mb_en, 0);
        repeat (2) @(negedge mclk);
        reset    = 1'b0;
        en_cnt   = 0;
        done_cnt = 0;
        spi_bits(32);
        check("t6_miso", {rx_s[0], rx_s[1], rx_s[2], rx_s[3]}, 0);
        check("t6_oe", spi_miso_oe, 0);
        check("t6_en", en_cnt, 0);
        repeat (HALF) @(negedge mclk);
        spi_scsn = 1'b1;
        repeat (20) @(negedge mclk);
        check("t6_nodone", done_cnt, 0);
        do_frame(16'h0021, {BSB_SEL, 1'b0, 2'b00}, 24 + 16);

        // Randomized frames
        for (int it = 0; it < 40; it++) begin
            ra = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3)))
                                             : 16'($urandom);
            rc = 8'($urandom);
            if ($urandom_range(0, 3) != 0) rc[7:3] = BSB_SEL;
            nb = $urandom_range(0, 5);
            for (int k = 0; k < nb + 1; k++) tx_s[3+k] = 8'($urandom);
            tot = 24 + 8*nb + (($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0);
            if ($urandom_range(0, 7) == 0) tot = $urandom_range(1, 23);
            do_frame(ra, rc, tot);
        end

        // Final BRAM contents versus the model
        nbad = 0;
        for (int w = 0; w < 2048; w++) begin
            if (bram[w] !== {mem_ref[4*w+3], mem_ref[4*w+2], mem_ref[4*w+1], mem_ref[4*w]})
                nbad++;
        end
        check("mem_words_bad", nbad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case stimulus stalls.
    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
